// File: rtl/iq_age_select_if.sv
// iq_age_select_if: dispatch, wakeup, issue and flush bundle of the issue queue.
// master drives dispatch/wakeup/issue-ready; slave is the queue itself.
interface iq_age_select_if #(
    parameter int DEPTH     = 16,
    parameter int ENQ_NUM   = 4,
    parameter int ISSUE_NUM = 4,
    parameter int WAKE_NUM  = 4,
    parameter int OPCODE    = 7,
    parameter int PRF_WIDTH = 6
);
    logic                           flush;
    logic [ENQ_NUM-1:0]             disp_valid;
    logic [ENQ_NUM*OPCODE-1:0]      disp_op;
    logic [ENQ_NUM*PRF_WIDTH-1:0]   disp_prs1;
    logic [ENQ_NUM*PRF_WIDTH-1:0]   disp_prs2;
    logic [ENQ_NUM*PRF_WIDTH-1:0]   disp_prd;
    logic [ENQ_NUM-1:0]             disp_prs1_v;
    logic [ENQ_NUM-1:0]             disp_prs2_v;
    logic [ENQ_NUM-1:0]             disp_prd_v;
    logic [ENQ_NUM-1:0]             disp_prs1_rdy;
    logic [ENQ_NUM-1:0]             disp_prs2_rdy;
    logic                           disp_ready;
    logic [WAKE_NUM-1:0]            wake_valid;
    logic [WAKE_NUM*PRF_WIDTH-1:0]  wake_tag;
    logic [ISSUE_NUM-1:0]           iss_ready;
    logic [ISSUE_NUM-1:0]           iss_valid;
    logic [ISSUE_NUM*OPCODE-1:0]    iss_op;
    logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prs1;
    logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prs2;
    logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prd;
    logic [ISSUE_NUM-1:0]           iss_prd_v;
    logic [$clog2(DEPTH):0]         free_cnt;

    modport master (
        output flush, disp_valid, disp_op, disp_prs1, disp_prs2, disp_prd,
        output disp_prs1_v, disp_prs2_v, disp_prd_v,
        output disp_prs1_rdy, disp_prs2_rdy,
        output wake_valid, wake_tag, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_prs1, iss_prs2,
        input  iss_prd, iss_prd_v, free_cnt
    );

    modport slave (
        input  flush, disp_valid, disp_op, disp_prs1, disp_prs2, disp_prd,
        input  disp_prs1_v, disp_prs2_v, disp_prd_v,
        input  disp_prs1_rdy, disp_prs2_rdy,
        input  wake_valid, wake_tag, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_prs1, iss_prs2,
        output iss_prd, iss_prd_v, free_cnt
    );
endinterface

// File: rtl/iq_age_select.sv
// iq_age_select: centralised issue queue with wakeup snoop and multi-port select.
// IQ_AGE_SELECT_EN defined: oldest-first select; undefined: ascending-index select.
module iq_age_select #(
    parameter int DEPTH     = 16,
    parameter int ENQ_NUM   = 4,
    parameter int ISSUE_NUM = 4,
    parameter int WAKE_NUM  = 4,
    parameter int OPCODE    = 7,
    parameter int PRF_WIDTH = 6
`ifdef IQ_AGE_SELECT_EN
    , parameter int AGE     = $clog2(DEPTH) + 1
`endif
) (
    input logic             clk,
    input logic             rst,
    iq_age_select_if.slave  iq
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                 valid;
        logic [OPCODE-1:0]    op;
        logic [PRF_WIDTH-1:0] prs1;
        logic [PRF_WIDTH-1:0] prs2;
        logic [PRF_WIDTH-1:0] prd;
        logic                 v1;
        logic                 v2;
        logic                 vd;
        logic                 r1;
        logic                 r2;
    } ent_t;

    ent_t ent_q [DEPTH];
    ent_t ent_d [DEPTH];

`ifdef IQ_AGE_SELECT_EN
    logic [AGE-1:0] age_q [DEPTH];
    logic [AGE-1:0] age_d [DEPTH];
    logic [AGE-1:0] age_ctr_q;
    logic [AGE-1:0] age_ctr_d;
    logic [AGE-1:0] acc;

    // Wrap-safe: live entries never span more than half the age space.
    function automatic logic older(input logic [AGE-1:0] a,
                                   input logic [AGE-1:0] b);
        logic [AGE-1:0] d;
        d = a - b;
        return d[AGE-1];
    endfunction
`endif

    logic [WAKE_NUM-1:0]           wv;
    logic [WAKE_NUM*PRF_WIDTH-1:0] wt;
    logic [DEPTH-1:0]              elig;
    logic [DEPTH-1:0]              taken;
    logic [DEPTH-1:0]              alloc_used;
    logic [ISSUE_NUM-1:0]          sel_v;
    logic [IW-1:0]                 sel_idx [ISSUE_NUM];
    logic [ENQ_NUM-1:0]            lane_ok;
    logic [IW-1:0]                 lane_idx [ENQ_NUM];
    logic [CW-1:0]                 free_cnt;
    logic                          can_disp;

    assign wv = iq.wake_valid;
    assign wt = iq.wake_tag;

    function automatic logic woken(input logic [PRF_WIDTH-1:0]          tag,
                                   input logic [WAKE_NUM-1:0]           v,
                                   input logic [WAKE_NUM*PRF_WIDTH-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_NUM; w++)
            if (v[w] && (t[w*PRF_WIDTH +: PRF_WIDTH] == tag)) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        free_cnt = '0;
        for (int e = 0; e < DEPTH; e++)
            if (!ent_q[e].valid) free_cnt = free_cnt + CW'(1);
    end

    assign can_disp      = (free_cnt >= CW'(ENQ_NUM));
    assign iq.disp_ready = can_disp;
    assign iq.free_cnt   = free_cnt;

    always_comb begin
        for (int e = 0; e < DEPTH; e++)
            elig[e] = ent_q[e].valid
                    && (!ent_q[e].v1 || ent_q[e].r1)
                    && (!ent_q[e].v2 || ent_q[e].r2);
    end

    // Each port scans entries not claimed by lower-numbered ports.
    always_comb begin
        taken = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            sel_v[k]   = 1'b0;
            sel_idx[k] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (elig[e] && !taken[e]) begin
                    if (!sel_v[k]) begin
                        sel_v[k]   = 1'b1;
                        sel_idx[k] = IW'(e);
                    end
`ifdef IQ_AGE_SELECT_EN
                    else if (older(age_q[e], age_q[sel_idx[k]])) begin
                        sel_idx[k] = IW'(e);
                    end
`endif
                end
            end
            if (sel_v[k]) taken[sel_idx[k]] = 1'b1;
        end
    end

    always_comb begin
        ent_d      = ent_q;
        alloc_used = '0;
`ifdef IQ_AGE_SELECT_EN
        age_d      = age_q;
        acc        = '0;
`endif
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_q[e].valid) begin
                ent_d[e].r1 = ent_q[e].r1
                            | (ent_q[e].v1 & woken(ent_q[e].prs1, wv, wt));
                ent_d[e].r2 = ent_q[e].r2
                            | (ent_q[e].v2 & woken(ent_q[e].prs2, wv, wt));
            end
        end
        for (int k = 0; k < ISSUE_NUM; k++)
            if (sel_v[k] && iq.iss_ready[k]) ent_d[sel_idx[k]].valid = 1'b0;
        // Allocation only sees slots free at the start of the cycle.
        for (int i = 0; i < ENQ_NUM; i++) begin
            lane_ok[i]  = 1'b0;
            lane_idx[i] = '0;
            if (iq.disp_valid[i] && can_disp) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (!ent_q[e].valid && !alloc_used[e] && !lane_ok[i]) begin
                        lane_ok[i]  = 1'b1;
                        lane_idx[i] = IW'(e);
                    end
                end
            end
            if (lane_ok[i]) begin
                alloc_used[lane_idx[i]] = 1'b1;
                ent_d[lane_idx[i]].valid = 1'b1;
                ent_d[lane_idx[i]].op    = iq.disp_op[i*OPCODE +: OPCODE];
                ent_d[lane_idx[i]].prs1  = iq.disp_prs1[i*PRF_WIDTH +: PRF_WIDTH];
                ent_d[lane_idx[i]].prs2  = iq.disp_prs2[i*PRF_WIDTH +: PRF_WIDTH];
                ent_d[lane_idx[i]].prd   = iq.disp_prd[i*PRF_WIDTH +: PRF_WIDTH];
                ent_d[lane_idx[i]].v1    = iq.disp_prs1_v[i];
                ent_d[lane_idx[i]].v2    = iq.disp_prs2_v[i];
                ent_d[lane_idx[i]].vd    = iq.disp_prd_v[i];
                ent_d[lane_idx[i]].r1    = iq.disp_prs1_rdy[i]
                    | woken(iq.disp_prs1[i*PRF_WIDTH +: PRF_WIDTH], wv, wt);
                ent_d[lane_idx[i]].r2    = iq.disp_prs2_rdy[i]
                    | woken(iq.disp_prs2[i*PRF_WIDTH +: PRF_WIDTH], wv, wt);
`ifdef IQ_AGE_SELECT_EN
                age_d[lane_idx[i]] = age_ctr_q + acc;
                acc = acc + AGE'(1);
`endif
            end
        end
`ifdef IQ_AGE_SELECT_EN
        age_ctr_d = age_ctr_q + acc;
`endif
        if (iq.flush) begin
            for (int e = 0; e < DEPTH; e++) ent_d[e].valid = 1'b0;
`ifdef IQ_AGE_SELECT_EN
            age_ctr_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_q[e] <= '0;
`ifdef IQ_AGE_SELECT_EN
                age_q[e] <= '0;
`endif
            end
`ifdef IQ_AGE_SELECT_EN
            age_ctr_q <= '0;
`endif
        end else begin
            ent_q <= ent_d;
`ifdef IQ_AGE_SELECT_EN
            age_q     <= age_d;
            age_ctr_q <= age_ctr_d;
`endif
        end
    end

    assign iq.iss_valid = sel_v;

    always_comb begin
        iq.iss_op    = '0;
        iq.iss_prs1  = '0;
        iq.iss_prs2  = '0;
        iq.iss_prd   = '0;
        iq.iss_prd_v = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            if (sel_v[k]) begin
                iq.iss_op[k*OPCODE +: OPCODE]      = ent_q[sel_idx[k]].op;
                iq.iss_prs1[k*PRF_WIDTH +: PRF_WIDTH] = ent_q[sel_idx[k]].prs1;
                iq.iss_prs2[k*PRF_WIDTH +: PRF_WIDTH] = ent_q[sel_idx[k]].prs2;
                iq.iss_prd[k*PRF_WIDTH +: PRF_WIDTH]  = ent_q[sel_idx[k]].prd;
                iq.iss_prd_v[k]                    = ent_q[sel_idx[k]].vd;
            end
        end
    end
endmodule
